// File: rtl/mem_responder_if.sv
// Request/response bundle between a control unit (master) and the memory responder (slave).
interface mem_responder_if;
  logic        MemRd;
  logic        MemWr;
  logic [1:0]  Type;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        M_busy;
  logic [1:0]  M_Wrong;

  modport master (
    output MemRd, MemWr, Type, Addr, WData,
    input  RData, M_busy, M_Wrong
  );

  modport slave (
    input  MemRd, MemWr, Type, Addr, WData,
    output RData, M_busy, M_Wrong
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word/halfword/byte memory responder with fault decode.
// IDLE accepts a request, BUSY counts down the latency, DONE lasts one cycle.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 3
) (
  input logic            CLK,
  input logic            RST,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;

  logic        req;
  logic        misalign;
  logic        invalid;
  logic [1:0]  fault_code;

  logic        acc_en;
  logic        acc_wr;
  logic [1:0]  acc_type;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [IDX_W-1:0] acc_idx;

  logic        m_busy;
  logic [1:0]  m_wrong;
  logic [3:0]  be;
  logic [31:0] wr_word;
  logic [31:0] rd_word;
  logic [31:0] rd_ext;
  logic        unused_addr_bits;

  // Fault decode on the live request; invalid outranks misalignment.
  always_comb begin
    req      = bus.MemRd | bus.MemWr;
    misalign = ((bus.Type == 2'b00) && (bus.Addr[1:0] != 2'b00)) ||
               ((bus.Type == 2'b01) && bus.Addr[0]);
    invalid  = (bus.Type == 2'b11) || ({1'b0, bus.Addr} >= ADDR_LIMIT) ||
               (bus.MemRd && bus.MemWr);
    if (invalid)
      fault_code = 2'b11;
    else if (misalign)
      fault_code = bus.MemWr ? 2'b10 : 2'b01;
    else
      fault_code = 2'b00;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    type_d    = type_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    acc_en    = 1'b0;
    acc_wr    = wr_q;
    acc_type  = type_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    m_busy    = 1'b0;
    m_wrong   = 2'b00;
    case (state_q)
      IDLE: begin
        if (req) begin
          m_wrong = fault_code;
          if (fault_code != 2'b00) begin
            state_d = DONE;
          end else begin
            m_busy  = 1'b1;
            addr_d  = bus.Addr;
            type_d  = bus.Type;
            wdata_d = bus.WData;
            wr_d    = bus.MemWr;
            if (LATENCY == 1) begin
              // Single-cycle access is performed straight from the live inputs.
              acc_en    = 1'b1;
              acc_wr    = bus.MemWr;
              acc_type  = bus.Type;
              acc_addr  = bus.Addr;
              acc_wdata = bus.WData;
              state_d   = DONE;
            end else begin
              cnt_d   = CNT_INIT;
              state_d = BUSY;
            end
          end
        end
      end
      BUSY: begin
        m_busy = 1'b1;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc_en  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    addr_q  <= addr_d;
    type_q  <= type_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
  end

  assign acc_idx          = acc_addr[IDX_W+1:2];
  assign unused_addr_bits = ^{acc_addr[31:IDX_W+2]};

  // Store data is replicated across lanes so each lane just picks its own slice.
  always_comb begin
    case (acc_type)
      2'b00: begin
        be      = 4'b1111;
        wr_word = acc_wdata;
      end
      2'b01: begin
        be      = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{acc_wdata[15:0]}};
      end
      default: begin
        be      = 4'b0001 << acc_addr[1:0];
        wr_word = {4{acc_wdata[7:0]}};
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      always_ff @(posedge CLK) begin
        if (!RST && acc_en && acc_wr && be[gi])
          lane_mem[acc_idx] <= wr_word[8*gi +: 8];
      end
      assign rd_word[8*gi +: 8] = lane_mem[acc_idx];
    end
  endgenerate

  always_comb begin
    case (acc_type)
      2'b00:   rd_ext = rd_word;
      2'b01:   rd_ext = acc_addr[1] ? {16'h0, rd_word[31:16]} : {16'h0, rd_word[15:0]};
      default: rd_ext = {24'h0, rd_word[8*acc_addr[1:0] +: 8]};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)
      rdata_q <= 32'h0;
    else if (acc_en && !acc_wr)
      rdata_q <= rd_ext;
  end

  assign bus.RData   = rdata_q;
  assign bus.M_busy  = m_busy;
  assign bus.M_Wrong = m_wrong;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=3 instance and one LATENCY=1 instance.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_responder_if bus3 ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
    .CLK(clk), .RST(rst), .bus(bus3.slave)
  );

  mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .CLK(clk), .RST(rst), .bus(bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on the LATENCY=3 instance; request held until DONE, dropped there.
  task automatic access3(input string tag, input logic rd, input logic wr,
                         input logic [1:0] typ, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] exp_wrong,
                         input int exp_busy);
    int busy_cnt;
    @(negedge clk);
    bus3.MemRd = rd;
    bus3.MemWr = wr;
    bus3.Type  = typ;
    bus3.Addr  = addr;
    bus3.WData = wdata;
    #1;
    check({tag, ".wrong_req"}, 32'(bus3.M_Wrong), 32'(exp_wrong));
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus3.M_busy) break;
      if (busy_cnt > 0) check({tag, ".wrong_busy"}, 32'(bus3.M_Wrong), 32'd0);
      busy_cnt++;
      @(negedge clk);
      #1;
    end
    if (busy_cnt == 0) begin
      @(negedge clk);
      #1;
    end
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, ".done_busy"}, 32'(bus3.M_busy), 32'd0);
    check({tag, ".done_wrong"}, 32'(bus3.M_Wrong), 32'd0);
    bus3.MemRd = 1'b0;
    bus3.MemWr = 1'b0;
    @(negedge clk);
    #1;
    $display("access %s rd=%0b wr=%0b type=%0d addr=%h wdata=%h rdata=%h busy=%0d",
             tag, rd, wr, typ, addr, wdata, bus3.RData, busy_cnt);
  endtask

  initial begin
    logic [3:0] busy_pat;
    bus3.MemRd = 0; bus3.MemWr = 0; bus3.Type = 0; bus3.Addr = 0; bus3.WData = 0;
    bus1.MemRd = 0; bus1.MemWr = 0; bus1.Type = 0; bus1.Addr = 0; bus1.WData = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.rdata", bus3.RData, 32'h0);
    check("rst.busy", 32'(bus3.M_busy), 32'd0);
    check("rst.wrong", 32'(bus3.M_Wrong), 32'd0);

    access3("wr_word_10", 0, 1, 2'b00, 32'h10, 32'hDEADBEEF, 2'b00, 3);
    access3("rd_word_10", 1, 0, 2'b00, 32'h10, 32'h0, 2'b00, 3);
    check("rd_word_10.rdata", bus3.RData, 32'hDEADBEEF);

    access3("wr_byte_11", 0, 1, 2'b10, 32'h11, 32'h0000005A, 2'b00, 3);
    access3("rd_word_10b", 1, 0, 2'b00, 32'h10, 32'h0, 2'b00, 3);
    check("rd_word_10b.rdata", bus3.RData, 32'hDEAD5AEF);
    access3("rd_half_12", 1, 0, 2'b01, 32'h12, 32'h0, 2'b00, 3);
    check("rd_half_12.rdata", bus3.RData, 32'h0000DEAD);
    access3("rd_half_10", 1, 0, 2'b01, 32'h10, 32'h0, 2'b00, 3);
    check("rd_half_10.rdata", bus3.RData, 32'h00005AEF);
    access3("rd_byte_11", 1, 0, 2'b10, 32'h11, 32'h0, 2'b00, 3);
    check("rd_byte_11.rdata", bus3.RData, 32'h0000005A);

    access3("rd_word_13", 1, 0, 2'b00, 32'h13, 32'h0, 2'b01, 0);
    check("rd_word_13.rdata", bus3.RData, 32'h0000005A);
    access3("wr_half_21", 0, 1, 2'b01, 32'h21, 32'hFFFF, 2'b10, 0);
    access3("rd_type11", 1, 0, 2'b11, 32'h10, 32'h0, 2'b11, 0);
    access3("wr_oor_1000", 0, 1, 2'b00, 32'h1000, 32'h11111111, 2'b11, 0);
    access3("rdwr_10", 1, 1, 2'b00, 32'h10, 32'h22222222, 2'b11, 0);
    check("fault.rdata", bus3.RData, 32'h0000005A);
    access3("rd_word_10c", 1, 0, 2'b00, 32'h10, 32'h0, 2'b00, 3);
    check("rd_word_10c.rdata", bus3.RData, 32'hDEAD5AEF);

    access3("wr_last_ffc", 0, 1, 2'b00, 32'hFFC, 32'hA5A55A5A, 2'b00, 3);
    access3("rd_last_ffc", 1, 0, 2'b00, 32'hFFC, 32'h0, 2'b00, 3);
    check("rd_last_ffc.rdata", bus3.RData, 32'hA5A55A5A);
    access3("wr_half_22", 0, 1, 2'b01, 32'h22, 32'h0000BEEF, 2'b00, 3);
    access3("rd_word_20", 1, 0, 2'b00, 32'h20, 32'h0, 2'b00, 3);
    check("rd_word_20.rdata[31:16]", {16'h0, bus3.RData[31:16]}, 32'h0000BEEF);

    // Reset lands on the final busy edge of a word write, so nothing is committed.
    access3("wr_zero_40", 0, 1, 2'b00, 32'h40, 32'h0, 2'b00, 3);
    @(negedge clk);
    bus3.MemWr = 1'b1; bus3.Type = 2'b00; bus3.Addr = 32'h40; bus3.WData = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus3.MemWr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.busy", 32'(bus3.M_busy), 32'd0);
    check("abort.rdata", bus3.RData, 32'h0);
    $display("access abort_wr_40 reset during busy");
    access3("rd_word_10d", 1, 0, 2'b00, 32'h10, 32'h0, 2'b00, 3);
    check("rd_word_10d.rdata", bus3.RData, 32'hDEAD5AEF);
    access3("rd_word_40", 1, 0, 2'b00, 32'h40, 32'h0, 2'b00, 3);
    check("rd_word_40.rdata", bus3.RData, 32'h00000000);

    // LATENCY=1 with a request held continuously alternates access and DONE.
    @(negedge clk);
    bus1.MemWr = 1'b1; bus1.Type = 2'b00; bus1.Addr = 32'h8; bus1.WData = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      #1;
      busy_pat[3-i] = bus1.M_busy;
      @(negedge clk);
    end
    bus1.MemWr = 1'b0;
    check("lat1.busy_pattern", 32'(busy_pat), 32'b1010);
    $display("access lat1_held_wr busy_pattern=%b", busy_pat);
    @(negedge clk);
    @(negedge clk);
    bus1.MemRd = 1'b1;
    #1;
    check("lat1.rd_busy", 32'(bus1.M_busy), 32'd1);
    @(negedge clk);
    #1;
    check("lat1.done_busy", 32'(bus1.M_busy), 32'd0);
    check("lat1.rdata", bus1.RData, 32'hCAFEF00D);
    bus1.MemRd = 1'b0;
    $display("access lat1_rd addr=00000008 rdata=%h", bus1.RData);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
